// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a start/done handshake.
// Single-cycle ops finish two cycles after the start edge. Multiply uses
// shift-add and divide/modulo use restoring division, one bit per cycle.
// Optional macro ALU_SEQ_FLAGS_EN adds registered carry/ovf outputs.
//
// Handshake: start is sampled only while the block is idle (state IDLE). An
// accepted start latches op/a/b, clears div0 and moves to CALC. busy is high
// for every CALC cycle. done is a one-cycle pulse in FINISH, where busy is
// already low. result/zero/div0 change only on entry to FINISH and then hold.
// A start while busy, or during the FINISH cycle, is ignored and not queued.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div0,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             carry,
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_LAND = 4'b0101;
    localparam logic [3:0] OP_LOR  = 4'b0110;
    localparam logic [3:0] OP_LNOT = 4'b0111;
    localparam logic [3:0] OP_BNOT = 4'b1000;
    localparam logic [3:0] OP_BAND = 4'b1001;
    localparam logic [3:0] OP_BOR  = 4'b1010;
    localparam logic [3:0] OP_BXOR = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // Latched request
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    // Iteration datapath. r_acc is the product accumulator for multiply and
    // the partial remainder for divide. r_sh holds the multiplier (shifting
    // right) or the dividend turning into the quotient (shifting left).
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_mcand;

    // Registered outputs
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_div0;
`ifdef ALU_SEQ_FLAGS_EN
    logic               r_carry;
    logic               r_ovf;
`endif

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_iterative;
    logic               w_last;
    logic               w_to_finish;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]     w_div_shifted;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_single_res;
    logic [WIDTH-1:0]   w_final_res;
    logic               w_final_div0;
`ifdef ALU_SEQ_FLAGS_EN
    logic [WIDTH:0]     w_add_ext;
    logic [WIDTH:0]     w_sub_ext;
    logic               w_final_carry;
    logic               w_final_ovf;
`endif

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_is_mul    = (r_op == OP_MUL);
    assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_MOD);
    assign w_b_zero    = (r_b == '0);
    // Division by zero skips the iterations entirely and finishes after one CALC cycle
    assign w_iterative = w_is_mul || (w_is_div && !w_b_zero);
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // One shift-add multiply step: add the shifted multiplicand when the current multiplier bit is set
    assign w_mul_acc = r_sh[0] ? (r_acc + r_mcand) : r_acc;

    // One restoring-division step: bring down the next dividend bit and
    // subtract the divisor if it fits. The partial remainder is always below
    // the divisor, so WIDTH+1 bits hold the shifted value without loss.
    assign w_div_shifted = {r_acc, r_sh[WIDTH-1]};
    assign w_div_diff    = w_div_shifted - {1'b0, r_b};
    assign w_div_ge      = !w_div_diff[WIDTH];
    assign w_div_rem     = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shifted[WIDTH-1:0];
    assign w_div_quo     = {r_sh[WIDTH-2:0], w_div_ge};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs decoded from the state register
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (!w_iterative || w_last) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_to_finish = (r_state == S_CALC) && (w_next_state == S_FINISH);

    // Results of the ops that complete in a single CALC cycle
    always_comb begin
        w_single_res = '0;
        case (r_op)
            OP_ADD:  w_single_res = r_a + r_b;
            OP_SUB:  w_single_res = r_a - r_b;
            OP_LAND: w_single_res = WIDTH'((r_a != '0) && (r_b != '0));
            OP_LOR:  w_single_res = WIDTH'((r_a != '0) || (r_b != '0));
            OP_LNOT: w_single_res = WIDTH'(r_a == '0);
            OP_BNOT: w_single_res = ~r_a;
            OP_BAND: w_single_res = r_a & r_b;
            OP_BOR:  w_single_res = r_a | r_b;
            OP_BXOR: w_single_res = r_a ^ r_b;
            OP_SHL:  w_single_res = {r_a[WIDTH-2:0], 1'b0};
            OP_SHR:  w_single_res = {1'b0, r_a[WIDTH-1:1]};
            default: w_single_res = '0;
        endcase
    end

    // Select the value captured on entry to FINISH, including the final iteration step
    always_comb begin
        w_final_res  = w_single_res;
        w_final_div0 = 1'b0;
        if (w_is_mul) begin
            w_final_res = w_mul_acc;
        end else if (r_op == OP_DIV) begin
            if (w_b_zero) begin
                w_final_res  = '1;
                w_final_div0 = 1'b1;
            end else begin
                w_final_res = w_div_quo;
            end
        end else if (r_op == OP_MOD) begin
            if (w_b_zero) begin
                w_final_res  = r_a;
                w_final_div0 = 1'b1;
            end else begin
                w_final_res = w_div_rem;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    assign w_add_ext = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub_ext = {1'b0, r_a} - {1'b0, r_b};

    // Carry/borrow and signed overflow for add and sub; cleared for every other op
    always_comb begin
        w_final_carry = 1'b0;
        w_final_ovf   = 1'b0;
        if (r_op == OP_ADD) begin
            w_final_carry = w_add_ext[WIDTH];
            w_final_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                            (w_add_ext[WIDTH-1] != r_a[WIDTH-1]);
        end else if (r_op == OP_SUB) begin
            w_final_carry = w_sub_ext[WIDTH];
            w_final_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                            (w_sub_ext[WIDTH-1] != r_a[WIDTH-1]);
        end
    end
`endif

    // Latch the request on accept, then advance the iterative datapath once per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sh    <= '0;
            r_mcand <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= a;
            r_sh    <= (op == OP_MUL) ? b : a;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_is_mul) begin
                r_acc   <= w_mul_acc;
                r_mcand <= {r_mcand[WIDTH-2:0], 1'b0};
                r_sh    <= {1'b0, r_sh[WIDTH-1:1]};
            end else if (w_is_div) begin
                r_acc <= w_div_rem;
                r_sh  <= w_div_quo;
            end
        end
    end

    // Output registers: div0 clears on accept; everything loads on entry to FINISH and then holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_div0   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_div0 <= 1'b0;
            end
            if (w_to_finish) begin
                r_result <= w_final_res;
                r_zero   <= (w_final_res == '0);
                r_div0   <= w_final_div0;
`ifdef ALU_SEQ_FLAGS_EN
                r_carry  <= w_final_carry;
                r_ovf    <= w_final_ovf;
`endif
            end
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign div0      = r_div0;
`ifdef ALU_SEQ_FLAGS_EN
    assign carry     = r_carry;
    assign ovf       = r_ovf;
`endif
    assign dbg_state = r_state;

endmodule
